// File: rtl/game_master_fsm_param.sv
// Game master FSM for the sprite shooter: sequences rounds, keeps score and lives,
// and drives registered per-sprite strobes computed from the next state.
module game_master_fsm_param #(
    parameter int unsigned N_TARGETS   = 3,
    parameter int unsigned N_LIVES     = 3,
    parameter int unsigned WIN_SCORE   = 3,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned LIFE_W      = 3,
    parameter int unsigned PROGRESSIVE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 launch_key,
    input  logic [N_TARGETS-1:0] target_within_screen,
    input  logic                 bullet_within_screen,
    input  logic                 spaceship_within_screen,
    input  logic                 collision,
    input  logic [N_TARGETS-1:0] collision_bullet,
    input  logic                 end_of_game_timer_running,
    output logic [N_TARGETS-1:0] target_write_xy,
    output logic [N_TARGETS-1:0] target_write_dxy,
    output logic [N_TARGETS-1:0] target_enable_update,
    output logic                 bullet_write_xy,
    output logic                 bullet_write_dxy,
    output logic                 bullet_enable_update,
    output logic                 spaceship_write_xy,
    output logic                 spaceship_write_dxy,
    output logic                 spaceship_enable_update,
    output logic [N_LIVES-1:0]   heart_visible,
    output logic                 end_of_game_timer_start,
    output logic                 game_won,
    output logic [SCORE_W-1:0]   score,
    output logic [LIFE_W-1:0]    n_lives,
    output logic [2:0]           state_out
);

    typedef enum logic [2:0] {
        START_GAME  = 3'd0,
        START_ROUND = 3'd1,
        AIM         = 3'd2,
        SHOOT       = 3'd3,
        END_ROUND   = 3'd4,
        END_GAME    = 3'd5,
        GAME_OVER   = 3'd6
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_SC = SCORE_W'(WIN_SCORE);
    localparam logic [LIFE_W-1:0]  LIVES0 = LIFE_W'(N_LIVES);

    state_t state, next_state;

    logic [SCORE_W-1:0]   score_nx, score_inc;
    logic [LIFE_W-1:0]    lives_nx, lives_dec;
    logic                 won_nx;
    logic [N_TARGETS-1:0] act, act_nx;
    logic                 hit, target_off;

    logic [N_TARGETS-1:0] t_xy_d, t_dxy_d, t_en_d;
    logic                 b_xy_d, b_dxy_d, b_en_d;
    logic                 s_xy_d, s_dxy_d, s_en_d;
    logic                 timer_start_d;
    logic [N_LIVES-1:0]   heart_d;

    // Progressive mode enables targets 0..score, capped at N_TARGETS.
    function automatic logic [N_TARGETS-1:0] active_mask(input logic [SCORE_W-1:0] s);
        logic [N_TARGETS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N_TARGETS; i++) begin
            m[i] = (PROGRESSIVE == 0) || (i <= 32'(s));
        end
        return m;
    endfunction

    assign act        = active_mask(score);
    assign hit        = |(collision_bullet & act);
    assign target_off = |(~target_within_screen & act);
    assign score_inc  = (score >= WIN_SC) ? WIN_SC : score + SCORE_W'(1);
    assign lives_dec  = (n_lives == '0) ? '0 : n_lives - LIFE_W'(1);

    always_comb begin
        next_state = state;
        score_nx   = score;
        lives_nx   = n_lives;
        won_nx     = game_won;
        case (state)
            START_GAME: begin
                next_state = START_ROUND;
                score_nx   = '0;
                lives_nx   = LIVES0;
                won_nx     = 1'b0;
            end
            START_ROUND: next_state = AIM;
            AIM: begin
                if (hit) begin
                    score_nx   = score_inc;
                    next_state = END_ROUND;
                end else if (launch_key) begin
                    next_state = SHOOT;
                end else if (target_off) begin
                    next_state = END_ROUND;
                end
            end
            SHOOT: begin
                // A spaceship hit voids any bullet hit in the same cycle.
                if (collision) begin
                    lives_nx   = lives_dec;
                    next_state = END_ROUND;
                end else if (hit) begin
                    score_nx   = score_inc;
                    next_state = END_ROUND;
                end else if (target_off || !bullet_within_screen || !spaceship_within_screen) begin
                    next_state = END_ROUND;
                end
            end
            END_ROUND: begin
                if (score >= WIN_SC) begin
                    won_nx     = 1'b1;
                    next_state = END_GAME;
                end else if (n_lives == '0) begin
                    won_nx     = 1'b0;
                    next_state = END_GAME;
                end else begin
                    next_state = START_ROUND;
                end
            end
            END_GAME: next_state = GAME_OVER;
            GAME_OVER: begin
                if (!end_of_game_timer_running && launch_key) begin
                    next_state = START_GAME;
                    score_nx   = '0;
                    lives_nx   = LIVES0;
                    won_nx     = 1'b0;
                end
            end
            default: next_state = START_GAME;
        endcase
    end

    // Strobes are decoded from the next state so the registered copies line up with state.
    assign act_nx = active_mask(score_nx);

    always_comb begin
        t_xy_d        = '0;
        t_dxy_d       = '0;
        t_en_d        = '0;
        b_xy_d        = 1'b0;
        b_dxy_d       = 1'b0;
        b_en_d        = 1'b0;
        s_xy_d        = 1'b0;
        s_dxy_d       = 1'b0;
        s_en_d        = 1'b0;
        timer_start_d = 1'b0;
        case (next_state)
            START_ROUND: begin
                t_xy_d  = act_nx;
                t_dxy_d = act_nx;
                b_xy_d  = 1'b1;
                s_xy_d  = 1'b1;
            end
            AIM: t_en_d = act_nx;
            SHOOT: begin
                t_en_d  = act_nx;
                b_en_d  = 1'b1;
                s_en_d  = 1'b1;
                b_dxy_d = (state != SHOOT);
                s_dxy_d = (state != SHOOT);
            end
            END_GAME: timer_start_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        heart_d = '0;
        for (int unsigned i = 0; i < N_LIVES; i++) begin
            heart_d[i] = (32'(lives_nx) > i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= START_GAME;
            score                   <= '0;
            n_lives                 <= LIVES0;
            game_won                <= 1'b0;
            heart_visible           <= '1;
            target_write_xy         <= '0;
            target_write_dxy        <= '0;
            target_enable_update    <= '0;
            bullet_write_xy         <= 1'b0;
            bullet_write_dxy        <= 1'b0;
            bullet_enable_update    <= 1'b0;
            spaceship_write_xy      <= 1'b0;
            spaceship_write_dxy     <= 1'b0;
            spaceship_enable_update <= 1'b0;
            end_of_game_timer_start <= 1'b0;
        end else begin
            state                   <= next_state;
            score                   <= score_nx;
            n_lives                 <= lives_nx;
            game_won                <= won_nx;
            heart_visible           <= heart_d;
            target_write_xy         <= t_xy_d;
            target_write_dxy        <= t_dxy_d;
            target_enable_update    <= t_en_d;
            bullet_write_xy         <= b_xy_d;
            bullet_write_dxy        <= b_dxy_d;
            bullet_enable_update    <= b_en_d;
            spaceship_write_xy      <= s_xy_d;
            spaceship_write_dxy     <= s_dxy_d;
            spaceship_enable_update <= s_en_d;
            end_of_game_timer_start <= timer_start_d;
        end
    end

    assign state_out = state;

endmodule
